// File: rtl/bypass_ctrl.sv
// Purpose: ID-to-EX bypass select/data generation with load-use stall request and stall counter.
// Latency: forward selects/data registered, visible one cycle after ID; stallreq_id is combinational.
// Backpressure: stall_i holds all registered state; flush_i clears EX-side outputs; load-use inserts a bubble.
module bypass_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_re,
  input  logic              id_rt_re,
  input  logic              ex_we,
  input  logic              mem_we,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              ex_is_load,
  output logic              stallreq_id,
  output logic              sel_rs_forward,
  output logic [DATA_W-1:0] rs_forward_data,
  output logic              sel_rt_forward,
  output logic [DATA_W-1:0] rt_forward_data,
  output logic [CNT_W-1:0]  lu_stall_cnt
);

  typedef enum logic {IDLE, LU_BUBBLE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;

  // A source is eligible only when ID is valid, the source is read, and it is not $0.
  logic rs_ok, rt_ok;
  logic rs_ex, rs_mem, rs_wb;
  logic rt_ex, rt_mem, rt_wb;

  assign rs_ok  = id_valid && id_rs_re && (id_rs != '0);
  assign rt_ok  = id_valid && id_rt_re && (id_rt != '0);

  assign rs_ex  = rs_ok && ex_we  && (ex_waddr  == id_rs);
  assign rs_mem = rs_ok && mem_we && (mem_waddr == id_rs);
  assign rs_wb  = rs_ok && wb_we  && (wb_waddr  == id_rs);
  assign rt_ex  = rt_ok && ex_we  && (ex_waddr  == id_rt);
  assign rt_mem = rt_ok && mem_we && (mem_waddr == id_rt);
  assign rt_wb  = rt_ok && wb_we  && (wb_waddr  == id_rt);

  // EX result of a load is not available yet; ID must wait one cycle for it to reach MEM.
  assign stallreq_id = (rs_ex || rt_ex) && ex_is_load;

  logic              rs_sel_nxt, rt_sel_nxt;
  logic [DATA_W-1:0] rs_dat_nxt, rt_dat_nxt;

  // Youngest-stage-wins forward selection; a load-use cycle turns into a bubble.
  always_comb begin
    rs_sel_nxt = 1'b0;
    rs_dat_nxt = '0;
    rt_sel_nxt = 1'b0;
    rt_dat_nxt = '0;
    if (!stallreq_id) begin
      if (rs_ex) begin
        rs_sel_nxt = 1'b1;
        rs_dat_nxt = ex_wdata;
      end else if (rs_mem) begin
        rs_sel_nxt = 1'b1;
        rs_dat_nxt = mem_wdata;
      end else if (rs_wb) begin
        rs_sel_nxt = 1'b1;
        rs_dat_nxt = wb_wdata;
      end
      if (rt_ex) begin
        rt_sel_nxt = 1'b1;
        rt_dat_nxt = ex_wdata;
      end else if (rt_mem) begin
        rt_sel_nxt = 1'b1;
        rt_dat_nxt = mem_wdata;
      end else if (rt_wb) begin
        rt_sel_nxt = 1'b1;
        rt_dat_nxt = wb_wdata;
      end
    end
  end

  // EX-side registers, bubble FSM and saturating load-use counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_rs_forward  <= 1'b0;
      rs_forward_data <= '0;
      sel_rt_forward  <= 1'b0;
      rt_forward_data <= '0;
      lu_stall_cnt    <= '0;
      state           <= IDLE;
    end else if (flush_i) begin
      sel_rs_forward  <= 1'b0;
      rs_forward_data <= '0;
      sel_rt_forward  <= 1'b0;
      rt_forward_data <= '0;
      state           <= IDLE;
    end else if (!stall_i) begin
      sel_rs_forward  <= rs_sel_nxt;
      rs_forward_data <= rs_dat_nxt;
      sel_rt_forward  <= rt_sel_nxt;
      rt_forward_data <= rt_dat_nxt;
      case (state)
        IDLE: begin
          if (stallreq_id) begin
            state <= LU_BUBBLE;
            if (lu_stall_cnt != '1) lu_stall_cnt <= lu_stall_cnt + CNT_ONE;
          end
        end
        LU_BUBBLE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // EX holds a bubble while in LU_BUBBLE, so a fresh load-use there means upstream is broken.
  a_no_lu_in_bubble: assert property (@(posedge clk) disable iff (rst)
    (state == LU_BUBBLE && !stall_i && !flush_i) |-> !stallreq_id);

endmodule

// File: tb/tb_bypass_ctrl.sv
// Purpose: directed scoreboard bench for bypass_ctrl (default widths plus a 2-bit counter instance).
// Latency: expectations are pushed per input cycle and checked 1 time unit after the following edge.
// Backpressure: stall_i/flush_i are driven as directed vectors; no handshake on the outputs.
module tb_bypass_ctrl;

  logic        clk;
  logic        rst, stall_i, flush_i, id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_rs_re, id_rt_re;
  logic        ex_we, mem_we, wb_we;
  logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
  logic [31:0] ex_wdata, mem_wdata, wb_wdata;
  logic        ex_is_load;

  logic        stallreq_id, sel_rs_forward, sel_rt_forward;
  logic [31:0] rs_forward_data, rt_forward_data;
  logic [15:0] lu_stall_cnt;

  logic        stallreq_id_2, sel_rs_forward_2, sel_rt_forward_2;
  logic [31:0] rs_forward_data_2, rt_forward_data_2;
  logic [1:0]  lu_stall_cnt_2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        stall;
    logic        srs;
    logic [31:0] drs;
    logic        srt;
    logic [31:0] drt;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  bypass_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
    .ex_wdata(ex_wdata), .mem_wdata(mem_wdata), .wb_wdata(wb_wdata),
    .ex_is_load(ex_is_load), .stallreq_id(stallreq_id),
    .sel_rs_forward(sel_rs_forward), .rs_forward_data(rs_forward_data),
    .sel_rt_forward(sel_rt_forward), .rt_forward_data(rt_forward_data),
    .lu_stall_cnt(lu_stall_cnt)
  );

  bypass_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
    .ex_wdata(ex_wdata), .mem_wdata(mem_wdata), .wb_wdata(wb_wdata),
    .ex_is_load(ex_is_load), .stallreq_id(stallreq_id_2),
    .sel_rs_forward(sel_rs_forward_2), .rs_forward_data(rs_forward_data_2),
    .sel_rt_forward(sel_rt_forward_2), .rt_forward_data(rt_forward_data_2),
    .lu_stall_cnt(lu_stall_cnt_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string f, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%0h expected=%0h", nm, f, got, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "stallreq_id", {31'd0, stallreq_id}, {31'd0, e.stall});
        chk(e.name, "sel_rs", {31'd0, sel_rs_forward}, {31'd0, e.srs});
        chk(e.name, "rs_data", rs_forward_data, e.drs);
        chk(e.name, "sel_rt", {31'd0, sel_rt_forward}, {31'd0, e.srt});
        chk(e.name, "rt_data", rt_forward_data, e.drt);
        chk(e.name, "cnt", {16'd0, lu_stall_cnt}, {16'd0, e.cnt});
        chk(e.name, "cnt_w2", {30'd0, lu_stall_cnt_2}, (e.cnt > 16'd3) ? 32'd3 : {16'd0, e.cnt});
      end
    end
  end

  task automatic clr();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; id_valid = 1'b0;
    id_rs = '0; id_rt = '0; id_rs_re = 1'b0; id_rt_re = 1'b0;
    ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
    ex_waddr = '0; mem_waddr = '0; wb_waddr = '0;
    ex_wdata = '0; mem_wdata = '0; wb_wdata = '0;
    ex_is_load = 1'b0;
  endtask

  // Load in EX writing r7 while ID reads r7 through rt.
  task automatic set_lu();
    id_valid = 1'b1; id_rt = 5'd7; id_rt_re = 1'b1;
    ex_we = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h99; ex_is_load = 1'b1;
  endtask

  task automatic go(input string nm, input logic st, input logic srs, input logic [31:0] drs,
                    input logic srt, input logic [31:0] drt, input logic [15:0] cnt);
    exp_t e;
    e.name = nm; e.stall = st; e.srs = srs; e.drs = drs; e.srt = srt; e.drt = drt; e.cnt = cnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    clr(); rst = 1'b1;
    go("reset", 0, 0, 0, 0, 0, 0);

    clr(); id_valid = 1; id_rs = 3; id_rs_re = 1;
    ex_we = 1; ex_waddr = 3; ex_wdata = 32'h11; mem_we = 1; mem_waddr = 3; mem_wdata = 32'h22;
    go("ex_over_mem", 0, 1, 32'h11, 0, 0, 0);

    clr(); id_valid = 1; id_rs = 3; id_rt = 3; id_rs_re = 1; id_rt_re = 1;
    ex_we = 1; ex_waddr = 4; ex_wdata = 32'h77; mem_we = 1; mem_waddr = 3; mem_wdata = 32'h22;
    go("rs_eq_rt", 0, 1, 32'h22, 1, 32'h22, 0);

    clr(); id_valid = 1; id_rs = 9; id_rs_re = 1;
    mem_we = 1; mem_waddr = 9; mem_wdata = 32'h33; wb_we = 1; wb_waddr = 9; wb_wdata = 32'h44;
    go("mem_over_wb", 0, 1, 32'h33, 0, 0, 0);

    clr(); id_valid = 1; id_rt = 5; id_rt_re = 1; wb_we = 1; wb_waddr = 5; wb_wdata = 32'hCAFE;
    go("wb_rt", 0, 0, 0, 1, 32'hCAFE, 0);

    clr(); id_valid = 1; id_rt = 0; id_rt_re = 1; wb_we = 1; wb_waddr = 0; wb_wdata = 32'hCAFE;
    ex_we = 1; ex_waddr = 0; ex_is_load = 1;
    go("r0_never", 0, 0, 0, 0, 0, 0);

    clr(); id_valid = 1; id_rs = 5; wb_we = 1; wb_waddr = 5; wb_wdata = 32'hCAFE;
    go("re_off", 0, 0, 0, 0, 0, 0);

    clr(); set_lu(); id_valid = 0;
    go("id_invalid", 0, 0, 0, 0, 0, 0);

    clr(); id_valid = 1; id_rs = 7; id_rs_re = 1;
    ex_we = 1; ex_waddr = 7; ex_wdata = 32'h99; ex_is_load = 1;
    mem_we = 1; mem_waddr = 7; mem_wdata = 32'h55;
    go("lu_stall", 1, 0, 0, 0, 0, 1);

    clr(); id_valid = 1; id_rs = 7; id_rs_re = 1; mem_we = 1; mem_waddr = 7; mem_wdata = 32'hBEEF;
    go("lu_mem_fwd", 0, 1, 32'hBEEF, 0, 0, 1);

    clr(); id_valid = 1; id_rs = 3; id_rs_re = 1; ex_we = 1; ex_waddr = 3; ex_wdata = 32'h11;
    go("pre_stall", 0, 1, 32'h11, 0, 0, 1);

    clr(); stall_i = 1; set_lu();
    go("stall_lu", 1, 1, 32'h11, 0, 0, 1);
    clr(); stall_i = 1; id_valid = 1; id_rt = 5; id_rt_re = 1; wb_we = 1; wb_waddr = 5; wb_wdata = 32'hCAFE;
    go("stall_wb", 0, 1, 32'h11, 0, 0, 1);
    clr(); stall_i = 1; id_valid = 1; id_rs = 9; id_rs_re = 1; mem_we = 1; mem_waddr = 9; mem_wdata = 32'h33;
    go("stall_mem", 0, 1, 32'h11, 0, 0, 1);

    clr(); flush_i = 1; stall_i = 1; set_lu();
    go("flush", 1, 0, 0, 0, 0, 1);

    clr(); set_lu(); go("lu2", 1, 0, 0, 0, 0, 2);
    clr();           go("idle2", 0, 0, 0, 0, 0, 2);
    clr(); set_lu(); go("lu3", 1, 0, 0, 0, 0, 3);
    clr();           go("idle3", 0, 0, 0, 0, 0, 3);
    clr(); set_lu(); go("lu4", 1, 0, 0, 0, 0, 4);
    clr(); stall_i = 1;
    go("hold_bubble", 0, 0, 0, 0, 0, 4);

    clr(); rst = 1; stall_i = 1; set_lu();
    go("rst_mid", 1, 0, 0, 0, 0, 0);

    clr(); set_lu(); go("lu_after_rst", 1, 0, 0, 0, 0, 1);
    clr(); id_valid = 1; id_rt = 7; id_rt_re = 1; mem_we = 1; mem_waddr = 7; mem_wdata = 32'h1234;
    go("end_fwd", 0, 0, 0, 1, 32'h1234, 1);

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
